// File: rtl/half_adder_d_pkg.sv
// ---------------------------------------------------------------------------
// half_adder_d_pkg
//   Shared constants for the half_adder_d cell:
//     CNT_W_DEFAULT      default width of the saturating carry-event counter
//     COMBO_00..COMBO_11 2-bit input-pair indices ({A,B}, A is the MSB) used
//                        to address bits of the combo_seen coverage vector
//     carry_cnt_max()    all-ones saturation value for a counter of width w
// ---------------------------------------------------------------------------
package half_adder_d_pkg;

   localparam int CNT_W_DEFAULT = 8;

   localparam logic [1:0] COMBO_00 = 2'b00;
   localparam logic [1:0] COMBO_01 = 2'b01;
   localparam logic [1:0] COMBO_10 = 2'b10;
   localparam logic [1:0] COMBO_11 = 2'b11;

   // Largest value a w-bit counter can hold; widths of 64 and above clamp
   // to all-ones so the shift never overflows.
   function automatic longint unsigned carry_cnt_max(input int unsigned w);
      if (w >= 64) begin
         return 64'hFFFF_FFFF_FFFF_FFFF;
      end
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/half_adder_core.sv
// ---------------------------------------------------------------------------
// half_adder_core
//   Purely combinational single-bit half adder.
//   Ports:
//     a, b   in   addend bits
//     sum    out  a ^ b
//     carry  out  a & b
// ---------------------------------------------------------------------------
module half_adder_core (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/half_adder_d.sv
// ---------------------------------------------------------------------------
// half_adder_d
//   Half adder leaf cell with immediate combinational outputs, registered
//   copies, sticky input-pair coverage and a saturating carry-event counter.
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous, active-high reset
//     A, B        in   addend bits
//     sum         out  combinational A ^ B (valid during reset too)
//     carry       out  combinational A & B (valid during reset too)
//     sum_r       out  sum captured on each rising clk edge
//     carry_r     out  carry captured on each rising clk edge
//     combo_seen  out  sticky bit per sampled input pair, index {A,B}
//     all_seen    out  all four input pairs have been sampled
//     carry_cnt   out  edges that sampled carry==1, saturating at all-ones
// ---------------------------------------------------------------------------
module half_adder_d
   import half_adder_d_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   output logic             sum,
   output logic             carry,
   output logic             sum_r,
   output logic             carry_r,
   output logic [3:0]       combo_seen,
   output logic             all_seen,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(carry_cnt_max(CNT_W));

   logic             sum_core;
   logic             carry_core;
   logic [1:0]       combo_idx;

   logic             sum_reg;
   logic             carry_reg;
   logic [3:0]       combo_seen_reg;
   logic [3:0]       combo_seen_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   half_adder_core u_core (
      .a     (A),
      .b     (B),
      .sum   (sum_core),
      .carry (carry_core)
   );

   assign combo_idx = {A, B};

   // Each coverage bit latches high the first time its input pair is sampled
   // and only reset can clear it again.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_seen
         assign combo_seen_next[gi] = combo_seen_reg[gi] | (combo_idx == 2'(gi));
      end
   endgenerate

   // Saturate rather than wrap so a long run of carries never reads as few.
   assign cnt_next = (carry_core && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_W'(1) : cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_reg        <= 1'b0;
         carry_reg      <= 1'b0;
         combo_seen_reg <= 4'b0000;
         cnt_reg        <= '0;
      end else begin
         sum_reg        <= sum_core;
         carry_reg      <= carry_core;
         combo_seen_reg <= combo_seen_next;
         cnt_reg        <= cnt_next;
      end
   end

   assign sum        = sum_core;
   assign carry      = carry_core;
   assign sum_r      = sum_reg;
   assign carry_r    = carry_reg;
   assign combo_seen = combo_seen_reg;
   assign all_seen   = &combo_seen_reg;
   assign carry_cnt  = cnt_reg;

endmodule

// File: tb/tb_half_adder_d.sv
// ---------------------------------------------------------------------------
// tb_half_adder_d
//   Two instances share stimulus: u_dut8 (CNT_W=8) and u_dut2 (CNT_W=2, for
//   saturation). Expected values come from a truth-table array, hand-written
//   sequences and an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_half_adder_d;
   import half_adder_d_pkg::*;

   logic       clk;
   logic       rst;
   logic       A;
   logic       B;
   logic       run_clk;

   logic       s8, c8, sr8, cr8, all8;
   logic [3:0] seen8;
   logic [7:0] cnt8;
   logic       s2, c2, sr2, cr2, all2;
   logic [3:0] seen2;
   logic [1:0] cnt2;

   int checks;
   int failures;

   half_adder_d #(.CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .A(A), .B(B),
      .sum(s8), .carry(c8), .sum_r(sr8), .carry_r(cr8),
      .combo_seen(seen8), .all_seen(all8), .carry_cnt(cnt8)
   );

   half_adder_d #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .A(A), .B(B),
      .sum(s2), .carry(c2), .sum_r(sr2), .carry_r(cr2),
      .combo_seen(seen2), .all_seen(all2), .carry_cnt(cnt2)
   );

   // Clock only toggles once enabled, so the truth-table phase runs clockless.
   initial clk = 1'b0;
   always #5 if (run_clk) clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, "_sum_r"},   32'(sr8),   32'd0);
      check({tag, "_carry_r"}, 32'(cr8),   32'd0);
      check({tag, "_seen8"},   32'(seen8), 32'd0);
      check({tag, "_all8"},    32'(all8),  32'd0);
      check({tag, "_cnt8"},    32'(cnt8),  32'd0);
      check({tag, "_cnt2"},    32'(cnt2),  32'd0);
   endtask

   // Reference model state: which pairs were seen, carry-event counts.
   bit seen_m [4];
   int cnt8_m;
   int cnt2_m;

   function automatic logic [3:0] seen_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = seen_m[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) seen_m[i] = 1'b0;
      cnt8_m = 0;
      cnt2_m = 0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic a;
      logic b;
      logic s;
      logic c;
   } vec_t;

   vec_t tt[4];

   initial begin
      int a_i, b_i, tot, exp_cnt8;
      logic [3:0] pairs [4];
      logic [1:0] sat_exp [5];

      checks   = 0;
      failures = 0;
      run_clk  = 1'b0;
      rst      = 1'b1;
      A        = 1'b0;
      B        = 1'b0;
      model_reset();

      tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
      tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
      tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
      tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

      #1;
      check_regs_zero("reset");

      // Combinational truth table, no clock, reset held.
      for (int i = 0; i < 4; i++) begin
         A = tt[i].a;
         B = tt[i].b;
         #1;
         $display("tt A=%0b B=%0b sum=%0b carry=%0b", A, B, s8, c8);
         check($sformatf("tt%0d_sum", i),    32'(s8), 32'(tt[i].s));
         check($sformatf("tt%0d_carry", i),  32'(c8), 32'(tt[i].c));
         check($sformatf("tt%0d_sum2", i),   32'(s2), 32'(tt[i].s));
         check($sformatf("tt%0d_carry2", i), 32'(c2), 32'(tt[i].c));
         #99;
      end
      check_regs_zero("tt_reset_hold");

      // Release reset while the clock is still stopped, then start it.
      A = 1'b0;
      B = 1'b0;
      rst = 1'b0;
      #2;
      run_clk = 1'b1;
      #1;

      // Registered path: 01 then 11, each visible one edge after the change.
      A = 1'b0; B = 1'b1;
      check("reg_hold_before_edge", 32'(sr8), 32'd0);
      tick();
      $display("reg A=0 B=1 sum_r=%0b carry_r=%0b", sr8, cr8);
      check("reg01_sum_r",   32'(sr8), 32'd1);
      check("reg01_carry_r", 32'(cr8), 32'd0);
      A = 1'b1; B = 1'b1;
      #1;
      check("reg11_not_yet", 32'(cr8), 32'd0);
      tick();
      $display("reg A=1 B=1 sum_r=%0b carry_r=%0b", sr8, cr8);
      check("reg11_sum_r",   32'(sr8), 32'd0);
      check("reg11_carry_r", 32'(cr8), 32'd1);

      // Coverage: 00,01,10 then 11 then back to 00.
      pulse_reset();
      pairs[0] = COMBO_00;
      pairs[1] = COMBO_01;
      pairs[2] = COMBO_10;
      pairs[3] = COMBO_11;
      for (int i = 0; i < 4; i++) begin
         {A, B} = pairs[i];
         tick();
         $display("cov A=%0b B=%0b combo_seen=%04b all_seen=%0b", A, B, seen8, all8);
      end
      // After 00,01,10 the last loop step added 11; re-derive the earlier state
      // by resetting and replaying the first three pairs.
      check("cov_all_1111", 32'(seen8), 32'hF);
      check("cov_all_seen", 32'(all8),  32'd1);
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         {A, B} = pairs[i];
         tick();
      end
      $display("cov after 00,01,10 combo_seen=%04b all_seen=%0b", seen8, all8);
      check("cov_0111",       32'(seen8), 32'h7);
      check("cov_0111_all",   32'(all8),  32'd0);
      {A, B} = COMBO_11;
      tick();
      check("cov_1111",       32'(seen8), 32'hF);
      check("cov_1111_all",   32'(all8),  32'd1);
      {A, B} = COMBO_00;
      tick();
      $display("cov back to 00 combo_seen=%04b all_seen=%0b", seen8, all8);
      check("cov_sticky",     32'(seen8), 32'hF);
      check("cov_sticky_all", 32'(all8),  32'd1);
      check("cov_cnt8",       32'(cnt8),  32'd1);

      // Saturation: hold 11 for five edges on the 2-bit counter.
      pulse_reset();
      sat_exp[0] = 2'd1;
      sat_exp[1] = 2'd2;
      sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3;
      sat_exp[4] = 2'd3;
      A = 1'b1; B = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         $display("sat edge %0d carry_cnt2=%0d carry_cnt8=%0d", i + 1, cnt2, cnt8);
         check($sformatf("sat%0d_cnt2", i), 32'(cnt2), 32'(sat_exp[i]));
         check($sformatf("sat%0d_cnt8", i), 32'(cnt8), 32'(i + 1));
      end

      // Async reset between edges: registers clear without an edge.
      #2;
      rst = 1'b1;
      #1;
      $display("async rst sum_r=%0b carry_r=%0b seen=%04b cnt8=%0d", sr8, cr8, seen8, cnt8);
      check_regs_zero("async");
      check("async_sum",   32'(s8), 32'd0);
      check("async_carry", 32'(c8), 32'd1);
      A = 1'b0;
      #1;
      check("async_sum_track",   32'(s8), 32'd1);
      check("async_carry_track", 32'(c8), 32'd0);
      tick();
      check_regs_zero("async_edge");
      rst = 1'b0;
      model_reset();
      tick();
      check("post_rst_sum_r", 32'(sr8),   32'd1);
      check("post_rst_seen",  32'(seen8), 32'h2);

      // Randomised run against the arithmetic model.
      pulse_reset();
      for (int n = 0; n < 120; n++) begin
         a_i = int'($urandom_range(1, 0));
         b_i = int'($urandom_range(1, 0));
         A = a_i[0];
         B = b_i[0];
         tot = a_i + b_i;
         seen_m[a_i * 2 + b_i] = 1'b1;
         if (tot == 2) begin
            cnt8_m = (cnt8_m < 255) ? cnt8_m + 1 : 255;
            cnt2_m = (cnt2_m < 3)   ? cnt2_m + 1 : 3;
         end
         #1;
         check("rnd_sum",   32'(s8), 32'(tot % 2));
         check("rnd_carry", 32'(c8), 32'(tot / 2));
         tick();
         exp_cnt8 = cnt8_m;
         $display("txn %0d A=%0b B=%0b sum_r=%0b carry_r=%0b seen=%04b cnt8=%0d cnt2=%0d",
                  n, A, B, sr8, cr8, seen8, cnt8, cnt2);
         check("rnd_sum_r",    32'(sr8),   32'(tot % 2));
         check("rnd_carry_r",  32'(cr8),   32'(tot / 2));
         check("rnd_seen8",    32'(seen8), 32'(seen_vec()));
         check("rnd_all8",     32'(all8),  32'(seen_m[0] && seen_m[1] && seen_m[2] && seen_m[3]));
         check("rnd_cnt8",     32'(cnt8),  32'(exp_cnt8));
         check("rnd_cnt2",     32'(cnt2),  32'(cnt2_m));
         check("rnd_seen2",    32'(seen2), 32'(seen_vec()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
